fir_mac_sequencer: RTL
======================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter N, default 25: datapath half-width; product, accumulator and result are 2*N-bit signed.
REQ-002 Parameter TAPS, default 8: number of filter taps, legal range 2..256.
REQ-003 Parameter TW, default 3: tap index width, SHALL satisfy 2^TW >= TAPS.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  one-cycle strobe: new input sample present in the delay line source.
REQ-007 product  input  2*N signed  multiplier output for the current tap_idx, combinational in the same cycle.
REQ-008 shift_en  output  1  shifts the sample delay line by one position.
REQ-009 tap_idx  output  TW  coefficient/sample select for the multiplier.
REQ-010 bandera  output  1  accumulator hold flag (1 = hold, 0 = load) for the external Acumulador.
REQ-011 result  output  2*N signed  saturated filter output.
REQ-012 result_valid  output  1  one-cycle strobe, result updated.
REQ-013 result_sat  output  1  result was clamped; valid with result_valid, held until the next result.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 overrun  output  1  one-cycle pulse: sample_valid dropped.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT, MAC, DONE; outputs shift_en, bandera, busy, result_valid SHALL be decoded from state only (Moore).
REQ-017 IDLE -> SHIFT when sample_valid=1; otherwise the FSM stays in IDLE.
REQ-018 SHIFT (1 cycle): shift_en=1, internal acc cleared to 0 at the exiting edge, tap counter loaded with 0; -> MAC.
REQ-019 MAC (TAPS cycles): tap_idx = counter, bandera=0, acc <= sat(acc + product) each edge, counter increments; -> DONE at the edge where counter = TAPS-1.
REQ-020 On the final MAC edge, result and result_sat SHALL be loaded from sat(acc + product) and its clamp indication.
REQ-021 DONE (1 cycle): result_valid=1; -> SHIFT if sample_valid=1, else -> IDLE.
REQ-022 bandera SHALL be 1 in IDLE, SHIFT and DONE; tap_idx SHALL be 0 outside MAC.
REQ-023 Addition SHALL use 2*N+1 bits; the sum SHALL clamp to [-2^(2N-1), 2^(2N-1)-1]; result_sat SHALL be set if any clamp occurred during the sample.
REQ-024 Latency: with sample_valid sampled at edge E0, result_valid SHALL be high in the cycle after edge E0+TAPS+1.
REQ-025 sample_valid during SHIFT or MAC SHALL be ignored with overrun=1 on the next cycle; the computation in flight SHALL be unaffected.
REQ-026 sample_valid during DONE SHALL be accepted without overrun (back-to-back throughput, one sample per TAPS+2 cycles).
REQ-027 result and result_sat SHALL hold their value between result_valid strobes.

Reset
REQ-028 reset=1 SHALL, at the next rising edge, force IDLE and set acc=0, counter=0, result=0, result_sat=0, overrun=0; reset has priority over all other inputs.
REQ-029 Reset asserted mid-MAC SHALL abort the computation with no result_valid pulse; shift_en SHALL be 0 during reset.

Verification
REQ-030 Reset then idle 10 cycles -> busy=0, bandera=1, result=0, result_valid=0, no shift_en.
REQ-031 TAPS=8, one sample_valid, product=3 each MAC cycle -> shift_en 1 cycle, tap_idx 0..7, result=24, result_sat=0, result_valid exactly 10 cycles after strobe.
REQ-032 product=2^48 on all 8 taps -> result=2^49-1, result_sat=1; product=-2^48 -> result=-2^49, result_sat=1.
REQ-033 sample_valid pulsed during tap 3 -> overrun pulse 1 cycle, first result unchanged; strobe in DONE -> accepted, next SHIFT immediate, no overrun.
REQ-034 Reset at tap 5 -> next cycle IDLE, busy=0, no result_valid; following sample yields correct result from acc=0.
REQ-035 Alternating product +5/-2 over 8 taps -> result=12, result_sat=0; consecutive samples give independent sums.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a time-multiplexed FIR: shifts the delay line, walks the taps
// through an external multiplier and accumulates with saturation.
module fir_mac_sequencer #(
    parameter int N    = 25,
    parameter int TAPS = 8,
    parameter int TW   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic signed [2*N-1:0] product,
    output logic                  shift_en,
    output logic [TW-1:0]         tap_idx,
    output logic                  bandera,
    output logic signed [2*N-1:0] result,
    output logic                  result_valid,
    output logic                  result_sat,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, MAC, DONE} state_t;

    localparam logic [TW-1:0]         LAST = TW'(TAPS - 1);
    localparam logic signed [2*N-1:0] MAXV = {1'b0, {(2*N-1){1'b1}}};
    localparam logic signed [2*N-1:0] MINV = {1'b1, {(2*N-1){1'b0}}};

    state_t                state;
    logic signed [2*N-1:0] acc;
    logic [TW-1:0]         count;
    logic                  sat_seen;
    logic [2*N:0]          sum_wide;
    logic signed [2*N-1:0] sum_sat;
    logic                  sum_clamp;

    // One guard bit: overflow shows as the top two bits of the sum disagreeing.
    always_comb begin
        sum_wide  = {acc[2*N-1], acc} + {product[2*N-1], product};
        sum_clamp = sum_wide[2*N] ^ sum_wide[2*N-1];
        if (!sum_clamp)
            sum_sat = sum_wide[2*N-1:0];
        else if (sum_wide[2*N])
            sum_sat = MINV;
        else
            sum_sat = MAXV;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            sat_seen   <= 1'b0;
            result     <= '0;
            result_sat <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= sample_valid && (state == SHIFT || state == MAC);
            case (state)
                IDLE: begin
                    if (sample_valid)
                        state <= SHIFT;
                end
                SHIFT: begin
                    acc      <= '0;
                    count    <= '0;
                    sat_seen <= 1'b0;
                    state    <= MAC;
                end
                MAC: begin
                    acc      <= sum_sat;
                    sat_seen <= sat_seen | sum_clamp;
                    count    <= count + 1'b1;
                    if (count == LAST) begin
                        result     <= sum_sat;
                        result_sat <= sat_seen | sum_clamp;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= sample_valid ? SHIFT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gating keeps the delay line frozen during a reset issued in SHIFT.
    assign shift_en     = (state == SHIFT) && !reset;
    assign bandera      = (state != MAC);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign tap_idx      = (state == MAC) ? count : '0;

endmodule
